// File: rtl/paolaunisa_top0.sv
// Leaky integrate-and-fire neuron in a Tiny Tapeout user tile.
// Define PAOLA_SPIKE_CNT_EN to add an 8-bit spike counter selectable onto uo_out.
module paolaunisa_top0 #(
   parameter logic [7:0] DEF_THRESH = 8'd128,
   parameter logic [2:0] DEF_LEAK   = 3'd2,
   parameter logic [7:0] DEF_REFRAC = 8'd2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [7:0] r_v;
   logic [7:0] r_thresh;
   logic [7:0] r_refrac;
   logic [7:0] r_rcnt;
   logic [2:0] r_leak;
   logic       r_spike;

   logic       w_cfg_we;
   logic [1:0] w_cfg_addr;
   logic [7:0] w_leak_term;
   logic [8:0] w_sum;
   logic [7:0] w_vn;
   logic       w_fire;
   logic       w_soft_clr;
   logic       w_spike_evt;
   logic       w_unused;

   function automatic logic [7:0] sat_u8(input logic [8:0] x);
      return x[8] ? 8'hFF : x[7:0];
   endfunction

   assign w_cfg_we    = uio_in[7];
   assign w_cfg_addr  = uio_in[1:0];
   assign w_unused    = ^uio_in[6:2];

   // V - (V >> leak) never underflows, so 9 bits hold the full sum of up to 510
   assign w_leak_term = (r_leak == 3'd0) ? 8'd0 : (r_v >> r_leak);
   assign w_sum       = {1'b0, r_v} - {1'b0, w_leak_term} + {1'b0, ui_in};
   assign w_vn        = sat_u8(w_sum);
   assign w_fire      = (w_vn >= r_thresh);

   assign w_soft_clr  = ena & w_cfg_we & (w_cfg_addr == 2'd3);
   assign w_spike_evt = ena & ~w_cfg_we & (r_rcnt == 8'd0) & w_fire;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_v      <= 8'd0;
         r_spike  <= 1'b0;
         r_rcnt   <= 8'd0;
         r_thresh <= DEF_THRESH;
         r_leak   <= DEF_LEAK;
         r_refrac <= DEF_REFRAC;
      end else if (ena) begin
         if (w_cfg_we) begin
            r_spike <= 1'b0;
            case (w_cfg_addr)
               2'd0:    r_thresh <= ui_in;
               2'd1:    r_leak   <= ui_in[2:0];
               2'd2:    r_refrac <= ui_in;
               default: begin
                  r_v    <= 8'd0;
                  r_rcnt <= 8'd0;
               end
            endcase
         end else if (r_rcnt != 8'd0) begin
            r_rcnt  <= r_rcnt - 8'd1;
            r_v     <= 8'd0;
            r_spike <= 1'b0;
         end else if (w_fire) begin
            r_spike <= 1'b1;
            r_v     <= 8'd0;
            r_rcnt  <= r_refrac;
         end else begin
            r_spike <= 1'b0;
            r_v     <= w_vn;
         end
      end
   end

`ifdef PAOLA_SPIKE_CNT_EN
   logic [7:0] r_scnt;
   logic       r_sel;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_scnt <= 8'd0;
         r_sel  <= 1'b0;
      end else if (ena) begin
         r_sel <= uio_in[6];
         if (w_soft_clr)
            r_scnt <= 8'd0;
         else if (w_spike_evt)
            r_scnt <= r_scnt + 8'd1;
      end
   end

   assign uo_out = r_sel ? r_scnt : r_v;
`else
   logic w_unused_evt;
   assign w_unused_evt = w_soft_clr ^ w_spike_evt;
   assign uo_out = r_v;
`endif

   assign uio_out = {4'b0000, (r_rcnt != 8'd0), r_spike, 2'b00};
   assign uio_oe  = 8'h3C;

endmodule

// File: tb/tb_paolaunisa_top0.sv
// Bench for paolaunisa_top0: hand-derived vector table plus a scoreboard fed by a behavioural neuron model.
module tb_paolaunisa_top0;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       ena;
      logic [7:0] ui;
      logic [7:0] uio;
      logic [7:0] exp_uo;
      logic [7:0] exp_uio;
   } vec_t;

   typedef struct {
      logic [7:0] uo;
      logic [7:0] uio;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   // behavioural neuron state
   logic [7:0] m_v, m_th, m_rf, m_rc, m_cnt;
   logic [2:0] m_lk;
   logic       m_spk, m_sel;

   paolaunisa_top0 dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%02h required=%02h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic rn, input logic e, input logic [7:0] ui, input logic [7:0] uio);
      int lt, vn;
      if (!rn) begin
         m_v = 0; m_spk = 0; m_rc = 0; m_cnt = 0; m_sel = 0;
         m_th = 8'd128; m_lk = 3'd2; m_rf = 8'd2;
      end else if (e) begin
         m_sel = uio[6];
         if (uio[7]) begin
            m_spk = 0;
            case (uio[1:0])
               2'd0: m_th = ui;
               2'd1: m_lk = ui[2:0];
               2'd2: m_rf = ui;
               default: begin m_v = 0; m_rc = 0; m_cnt = 0; end
            endcase
         end else if (m_rc != 0) begin
            m_rc = m_rc - 1; m_v = 0; m_spk = 0;
         end else begin
            lt = (m_lk == 0) ? 0 : (int'(m_v) >> m_lk);
            vn = int'(m_v) - lt + int'(ui);
            if (vn > 255) vn = 255;
            if (vn >= int'(m_th)) begin
               m_spk = 1; m_v = 0; m_rc = m_rf; m_cnt = m_cnt + 1;
            end else begin
               m_spk = 0; m_v = 8'(vn);
            end
         end
      end
   endtask

   function automatic exp_t model_out();
      exp_t x;
`ifdef PAOLA_SPIKE_CNT_EN
      x.uo = m_sel ? m_cnt : m_v;
`else
      x.uo = m_v;
`endif
      x.uio = {4'b0000, (m_rc != 0), m_spk, 2'b00};
      return x;
   endfunction

   task automatic cyc(input logic e, input logic [7:0] ui, input logic [7:0] uio);
      exp_t x;
      @(negedge clk);
      ena = e; ui_in = ui; uio_in = uio;
      model_step(rst_n, e, ui, uio);
      sb.push_back(model_out());
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("sb_uo", uo_out, x.uo);
      chk("sb_uio", uio_out, x.uio);
      chk("uio_oe", uio_oe, 8'h3C);
   endtask

   function automatic void add(input logic e, input logic [7:0] ui, input logic [7:0] uio,
                               input logic [7:0] euo, input logic [7:0] euio);
      vec_t v;
      v.ena = e; v.ui = ui; v.uio = uio; v.exp_uo = euo; v.exp_uio = euio;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [7:0] eq[11];
      rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
      eq = '{8'd10, 8'd18, 8'd24, 8'd28, 8'd31, 8'd34, 8'd36, 8'd37, 8'd38, 8'd39, 8'd40};

      // pure integration, leak disabled
      add(1, 8'h00, 8'h81, 8'd0, 8'h00);
      for (int k = 1; k <= 12; k++) add(1, 8'd10, 8'h00, 8'(10 * k), 8'h00);
      add(1, 8'd10, 8'h00, 8'd0, 8'h0C);
      add(1, 8'd10, 8'h00, 8'd0, 8'h08);
      add(1, 8'd10, 8'h00, 8'd0, 8'h00);
      add(1, 8'd10, 8'h00, 8'd10, 8'h00);
      // leak equilibrium at leak=2
      add(1, 8'h02, 8'h81, 8'd10, 8'h00);
      add(1, 8'h00, 8'h83, 8'd0, 8'h00);
      for (int k = 0; k < 20; k++) add(1, 8'd10, 8'h00, (k < 11) ? eq[k] : 8'd40, 8'h00);
      // ena low freezes everything, then soft clear keeps config
      for (int k = 0; k < 5; k++) add(0, 8'hFF, 8'h83, 8'd40, 8'h00);
      add(1, 8'h00, 8'h83, 8'd0, 8'h00);
      add(1, 8'd10, 8'h00, 8'd10, 8'h00);
      add(1, 8'd10, 8'h00, 8'd18, 8'h00);
      // saturation with thresh=255, refrac=0
      add(1, 8'hFF, 8'h80, 8'd18, 8'h00);
      add(1, 8'h00, 8'h81, 8'd18, 8'h00);
      add(1, 8'h00, 8'h82, 8'd18, 8'h00);
      add(1, 8'h00, 8'h83, 8'd0, 8'h00);
      add(1, 8'd200, 8'h00, 8'd200, 8'h00);
      add(1, 8'd200, 8'h00, 8'd0, 8'h04);
      add(1, 8'd200, 8'h00, 8'd200, 8'h00);
      // thresh=0: spike every neuron cycle; a config cycle forces spike low
      add(1, 8'h00, 8'h80, 8'd200, 8'h00);
      add(1, 8'h37, 8'h3C, 8'd0, 8'h04);
      add(1, 8'h00, 8'h00, 8'd0, 8'h04);
      add(1, 8'hFF, 8'h00, 8'd0, 8'h04);
      add(1, 8'h80, 8'h80, 8'd0, 8'h00);

      // reset held two clocks with live inputs
      cyc(1, 8'hAA, 8'h81);
      cyc(1, 8'hAA, 8'h81);
      chk("rst_uo", uo_out, 8'h00);
      chk("rst_uio", uio_out, 8'h00);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         cyc(tbl[i].ena, tbl[i].ui, tbl[i].uio);
         chk($sformatf("tbl%0d_uo", i), uo_out, tbl[i].exp_uo);
         chk($sformatf("tbl%0d_uio", i), uio_out, tbl[i].exp_uio);
      end

`ifdef PAOLA_SPIKE_CNT_EN
      cyc(1, 8'h00, 8'h83);
      cyc(1, 8'h00, 8'h80);
      for (int k = 0; k < 3; k++) cyc(1, 8'd5, 8'h00);
      cyc(1, 8'hFF, 8'h80);
      cyc(1, 8'h00, 8'h40);
      chk("scnt_three", uo_out, 8'd3);
      cyc(1, 8'h00, 8'hC3);
      chk("scnt_clear", uo_out, 8'd0);
      cyc(1, 8'h00, 8'h00);
      cyc(1, 8'h80, 8'h80);
`endif

      for (int k = 0; k < 300; k++) begin
         logic [7:0] u;
         u = 8'($urandom);
         u[7] = ($urandom_range(0, 7) == 0);
         cyc($urandom_range(0, 9) != 0, 8'($urandom), u);
      end

      // reset must wait for a clock edge
      cyc(1, 8'hFF, 8'h80);
      cyc(1, 8'h00, 8'h81);
      cyc(1, 8'h00, 8'h82);
      cyc(1, 8'h00, 8'h83);
      cyc(1, 8'd40, 8'h00);
      chk("pre_rst_v", uo_out, 8'd40);
      rst_n = 1'b0;
      #1;
      chk("sync_rst_hold", uo_out, 8'd40);
      cyc(1, 8'hAA, 8'h00);
      chk("sync_rst_clear", uo_out, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
